// File: rtl/lcd_vram_snapshot_if.sv
// VRAM-to-shadow snapshot bus: vsync/enable control, VRAM read port, shadow write port, status.
interface lcd_vram_snapshot_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  vsync;
  logic                  enable;
  logic                  cpu_req;
  logic [7:0]            src_addr;
  logic                  src_rd;
  logic [DATA_WIDTH-1:0] src_data;
  logic [7:0]            dst_addr;
  logic [DATA_WIDTH-1:0] dst_data;
  logic                  dst_we;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  modport slave (
    input  vsync, enable, cpu_req, src_data,
    output src_addr, src_rd, dst_addr, dst_data, dst_we, busy, frame_done, overrun
  );

  modport master (
    output vsync, enable, cpu_req, src_data,
    input  src_addr, src_rd, dst_addr, dst_data, dst_we, busy, frame_done, overrun
  );
endinterface

// File: rtl/lcd_vram_snapshot.sv
// Frame-coherent VRAM -> shadow buffer copy engine, started on vsync, CPU has read-port priority.
// Optional blank pass on vsync with LCD off: define LCD_SNAPSHOT_BLANK_EN.
module lcd_vram_snapshot #(
  parameter int unsigned COPY_LEN   = 160,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  lcd_vram_snapshot_if.slave bus
);

  localparam logic [7:0] LAST_ADDR = 8'(COPY_LEN - 1);

`ifdef LCD_SNAPSHOT_BLANK_EN
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN} state_t;
`endif

  state_t     r_state;
  logic [7:0] r_src_addr;
  logic [7:0] r_dst_addr;
  logic       r_dst_we;
  logic       r_frame_done;
  logic       r_overrun;
  logic       r_blank_wr;

  logic w_issue_rd;
  logic w_blank;
  logic w_issue;
  logic w_busy;

  assign w_issue_rd = (r_state == S_COPY) && !bus.cpu_req;
`ifdef LCD_SNAPSHOT_BLANK_EN
  assign w_blank    = (r_state == S_BLANK);
`else
  assign w_blank    = 1'b0;
`endif
  // A blank pass issues one shadow write per cycle regardless of CPU activity
  assign w_issue    = w_issue_rd | w_blank;
  assign w_busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_addr   <= 8'd0;
      r_dst_addr   <= 8'd0;
      r_dst_we     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_blank_wr   <= 1'b0;
    end else begin
      r_dst_we     <= w_issue;
      r_dst_addr   <= r_src_addr;
      r_frame_done <= (r_state == S_DRAIN);
      r_blank_wr   <= w_blank;
      if (bus.vsync && w_busy) r_overrun <= 1'b1;
      if (w_issue) r_src_addr <= r_src_addr + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.vsync) begin
            if (bus.enable) begin
              r_state    <= S_COPY;
              r_src_addr <= 8'd0;
            end
`ifdef LCD_SNAPSHOT_BLANK_EN
            else begin
              r_state    <= S_BLANK;
              r_src_addr <= 8'd0;
            end
`endif
          end
        end
        S_COPY: begin
          if (w_issue_rd && (r_src_addr == LAST_ADDR)) r_state <= S_DRAIN;
        end
`ifdef LCD_SNAPSHOT_BLANK_EN
        S_BLANK: begin
          if (r_src_addr == LAST_ADDR) r_state <= S_DRAIN;
        end
`endif
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.src_addr   = r_src_addr;
  assign bus.src_rd     = w_issue_rd;
  assign bus.dst_addr   = r_dst_addr;
  assign bus.dst_data   = r_blank_wr ? '0 : bus.src_data;
  assign bus.dst_we     = r_dst_we;
  assign bus.busy       = w_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_lcd_vram_snapshot.sv
// Directed bench for lcd_vram_snapshot: VRAM model with 1-cycle read latency and a shadow buffer model.
module tb_lcd_vram_snapshot;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_vram_snapshot_if #(.DATA_WIDTH(4)) bus ();

  lcd_vram_snapshot #(.COPY_LEN(160), .DATA_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] vram     [0:255];
  logic [3:0] shadow   [0:255];
  int         wr_epoch [0:255];
  int         epoch;
  int         total;
  int         bad;

  // VRAM: data valid the cycle after the read strobe
  always @(posedge clk) if (bus.src_rd) bus.src_data <= vram[bus.src_addr];

  always @(posedge clk) begin
    if (bus.dst_we) begin
      shadow[bus.dst_addr]   <= bus.dst_data;
      wr_epoch[bus.dst_addr] <= epoch;
    end
  end

  // Frame statistics gathered by run_frame
  int n_we, n_rd, first_we, fd_n, fd_cyc, last_busy, first_ovr;
  int stall_rd_bad, frz_bad, we_in_gap, restart_ok;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(input int k);
    for (int a = 0; a < 256; a++) vram[a] = 4'(a ^ (k * 3));
  endtask

  task automatic check_shadow(input string tag, input bit zero);
    int nbad;
    logic [3:0] exp;
    nbad = 0;
    for (int a = 0; a < 160; a++) begin
      exp = zero ? 4'd0 : vram[a];
      if (wr_epoch[a] != epoch || shadow[a] !== exp) nbad++;
    end
    check_eq(tag, nbad, 0);
  endtask

  // vsync sampled at edge 0; loop body c runs in cycle c
  task automatic run_frame(input bit en, input int stall_lo, input int stall_hi, input int frz,
                           input int en_drop, input int vs2, input int rst_cyc, input int ncyc);
    epoch++;
    n_we = 0; n_rd = 0; first_we = -1; fd_n = 0; fd_cyc = -1; last_busy = -1; first_ovr = -1;
    stall_rd_bad = 0; frz_bad = 0; we_in_gap = 0; restart_ok = 0;
    bus.enable = en;
    bus.vsync  = 1'b1;
    step();
    for (int c = 1; c <= ncyc; c++) begin
      bus.vsync   = (c == vs2);
      bus.cpu_req = (c >= stall_lo && c <= stall_hi);
      if (c == en_drop) bus.enable = 1'b0;
      if (c == rst_cyc) reset = 1'b1;
      if (c == rst_cyc + 2) reset = 1'b0;
      #1;
      if (c == rst_cyc) begin
        check_eq("rst_async_busy", int'(bus.busy), 0);
        check_eq("rst_async_we", int'(bus.dst_we), 0);
        check_eq("rst_async_addr", int'(bus.src_addr), 0);
        check_eq("rst_async_rd", int'(bus.src_rd), 0);
      end
      if (bus.dst_we) begin
        n_we++;
        if (first_we < 0) first_we = c;
        if (c >= stall_lo + 1 && c <= stall_hi + 1) we_in_gap++;
      end
      if (bus.src_rd) n_rd++;
      if (bus.frame_done) begin fd_n++; fd_cyc = c; end
      if (bus.busy) last_busy = c;
      if (bus.overrun && first_ovr < 0) first_ovr = c;
      if (bus.cpu_req && bus.src_rd) stall_rd_bad++;
      if (frz >= 0 && bus.cpu_req && bus.src_addr != 8'(frz)) frz_bad++;
      if (c == vs2 + 1 && bus.src_rd && bus.src_addr == 8'd0) restart_ok = 1;
      step();
    end
    bus.vsync   = 1'b0;
    bus.cpu_req = 1'b0;
    bus.enable  = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    total = 0; bad = 0; epoch = 0;
    reset = 1'b1;
    bus.vsync = 1'b0; bus.enable = 1'b1; bus.cpu_req = 1'b0; bus.src_data = 4'd0;
    for (int a = 0; a < 256; a++) begin shadow[a] = 4'd0; wr_epoch[a] = -1; end
    set_pattern(0);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_src_rd", int'(bus.src_rd), 0);
    check_eq("rst_dst_we", int'(bus.dst_we), 0);
    check_eq("rst_fd", int'(bus.frame_done), 0);
    check_eq("rst_ovr", int'(bus.overrun), 0);
    check_eq("rst_src_addr", int'(bus.src_addr), 0);
    check_eq("rst_dst_addr", int'(bus.dst_addr), 0);

    // Plain copy, VRAM[a] = a[3:0]
    run_frame(1'b1, -10, -10, -1, -1, -10, -10, 165);
    check_eq("plain_n_we", n_we, 160);
    check_eq("plain_n_rd", n_rd, 160);
    check_eq("plain_first_we", first_we, 2);
    check_eq("plain_fd_n", fd_n, 1);
    check_eq("plain_fd_cyc", fd_cyc, 162);
    check_eq("plain_last_busy", last_busy, 161);
    check_eq("plain_ovr", first_ovr, -1);
    check_shadow("plain_data", 1'b0);

    // CPU stall in cycles 10..14
    set_pattern(1);
    run_frame(1'b1, 10, 14, 9, -1, -10, -10, 170);
    check_eq("stall_rd", stall_rd_bad, 0);
    check_eq("stall_frozen", frz_bad, 0);
    check_eq("stall_we_gap", we_in_gap, 0);
    check_eq("stall_n_we", n_we, 160);
    check_eq("stall_fd_cyc", fd_cyc, 167);
    check_shadow("stall_data", 1'b0);

    // vsync in the frame_done cycle starts a new copy immediately
    set_pattern(2);
    run_frame(1'b1, -10, -10, -1, -1, 162, -10, 330);
    check_eq("b2b_restart", restart_ok, 1);
    check_eq("b2b_n_we", n_we, 320);
    check_eq("b2b_fd_n", fd_n, 2);
    check_eq("b2b_fd_cyc", fd_cyc, 324);
    check_eq("b2b_ovr", first_ovr, -1);
    check_shadow("b2b_data", 1'b0);

    // vsync mid-copy: ignored, overrun sticky
    set_pattern(3);
    run_frame(1'b1, -10, -10, -1, -1, 50, -10, 170);
    check_eq("ovr_first", first_ovr, 51);
    check_eq("ovr_n_we", n_we, 160);
    check_eq("ovr_fd_cyc", fd_cyc, 162);
    check_shadow("ovr_data", 1'b0);
    repeat (5) step();
    check_eq("ovr_sticky", int'(bus.overrun), 1);

    // Reset at cycle 80 abandons the copy
    run_frame(1'b1, -10, -10, -1, -1, -10, 80, 170);
    check_eq("abort_fd_n", fd_n, 0);
    check_eq("abort_ovr_clr", int'(bus.overrun), 0);
    check_eq("abort_busy", int'(bus.busy), 0);

    // Next vsync restarts from address 0
    set_pattern(4);
    run_frame(1'b1, -10, -10, -1, -1, -10, -10, 165);
    check_eq("restart_n_we", n_we, 160);
    check_eq("restart_fd_cyc", fd_cyc, 162);
    check_shadow("restart_data", 1'b0);

    // vsync with LCD off, CPU holding the port throughout
    run_frame(1'b0, 1, 170, -1, -1, -10, -10, 170);
    check_eq("off_src_rd", n_rd, 0);
`ifdef LCD_SNAPSHOT_BLANK_EN
    check_eq("blank_n_we", n_we, 160);
    check_eq("blank_first_we", first_we, 2);
    check_eq("blank_fd_cyc", fd_cyc, 162);
    check_eq("blank_last_busy", last_busy, 161);
    check_shadow("blank_data", 1'b1);
`else
    check_eq("off_n_we", n_we, 0);
    check_eq("off_busy", last_busy, -1);
    check_eq("off_fd_n", fd_n, 0);
`endif

    // enable dropped at cycle 20 does not stop the copy
    set_pattern(5);
    run_frame(1'b1, -10, -10, -1, 20, -10, -10, 165);
    check_eq("endrop_n_we", n_we, 160);
    check_eq("endrop_fd_cyc", fd_cyc, 162);
    check_shadow("endrop_data", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_vram_snapshot.md
Name: lcd_vram_snapshot

Overview:
- Frame-coherent copy engine between the CPU-side LCD VRAM (single read port, shared with CPU) and the display shadow buffer read by the video generator.
- Each vsync: streams all VRAM words (bank 0 at 0x00-0x4F, bank 1 at 0x50-0x9F) into the shadow buffer at identical addresses, so the video scan never shows a half-updated frame.
- Arbitrates the VRAM read port: CPU always has priority; the copy stalls while the CPU holds the port.

Parameters:
- COPY_LEN, 8'd160, number of words copied per frame (addresses 0 .. COPY_LEN-1).
- DATA_WIDTH, 4, VRAM word width (nibble RAM).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  single-cycle frame-start pulse from the video generator.
- enable  in  1  LCD on; sampled only on an accepted vsync.
- cpu_req  in  1  CPU owns the VRAM read port this cycle.
- src_addr  out  8  VRAM read address (registered counter).
- src_rd  out  1  VRAM read strobe (combinational: state==COPY && !cpu_req).
- src_data  in  DATA_WIDTH  VRAM read data, valid the cycle after src_rd.
- dst_addr  out  8  shadow buffer write address (registered).
- dst_data  out  DATA_WIDTH  shadow write data (combinational from src_data).
- dst_we  out  1  shadow write enable (registered).
- busy  out  1  copy in progress (state COPY or DRAIN).
- frame_done  out  1  one-cycle pulse after the final shadow write.
- overrun  out  1  sticky: a vsync arrived while busy.

Behaviour:
- Reset, asynchronous: state=IDLE, src_addr=0, dst_addr=0, dst_we=0, frame_done=0, overrun=0, so busy=0 and src_rd=0. Reset mid-copy abandons the copy, leaves the shadow buffer partially updated, and emits no frame_done. Reset wins over a simultaneous vsync.
- States:
  - IDLE: vsync && enable -> COPY, src_addr=0. vsync && !enable -> stay IDLE, no writes.
  - COPY: in each cycle with !cpu_req, src_rd=1 and src_addr increments at the edge. If the issued address == COPY_LEN-1, go to DRAIN. In a cycle with cpu_req=1, src_rd=0 and src_addr holds; any number of stall cycles is allowed.
  - DRAIN: lasts one cycle and carries the last write. -> IDLE with frame_done=1 registered for the following cycle.
- Read pipeline:
  - dst_we(t+1) = src_rd(t); dst_addr(t+1) = src_addr(t); dst_data = src_data.
  - Writes occur in issue order with no gaps except stall bubbles.
  - A stall in cycle t gives dst_we=0 in cycle t+1.
- Latency with no stalls: vsync sampled at edge 0 -> reads in cycles 1..160, writes in cycles 2..161, frame_done in cycle 162. busy is high in cycles 1..161 and low in cycle 162.
- vsync while busy is ignored; overrun<=1 and stays set until reset. vsync in the frame_done cycle (IDLE) is accepted normally.
- enable falling mid-copy has no effect; the copy completes.
- Address counters are 8 bits. COPY_LEN must be <= 256. src_addr never exceeds COPY_LEN-1 while src_rd=1.
- cpu_req asserted in the DRAIN cycle has no effect; the last write still occurs.

Optional Feature:
- Macro LCD_SNAPSHOT_BLANK_EN.
- Defined: vsync && !enable starts a blank pass, state BLANK.
  - Writes 0 to all COPY_LEN shadow addresses, one per cycle, ignoring cpu_req.
  - src_rd stays 0 throughout.
  - dst_data is forced to 0 during the pass.
  - Same DRAIN / frame_done / busy / overrun rules as COPY.
  - Timing: writes in cycles 2..161, frame_done in cycle 162.
- Not defined: vsync && !enable is ignored and the shadow buffer is untouched. The BLANK state does not exist.

Test Plan:
- Reset, then vsync with enable=1, cpu_req=0, VRAM[a]=a[3:0] -> 160 writes, dst_addr 0x00..0x9F, dst_data=a[3:0], first dst_we in cycle 2, frame_done in cycle 162 only, overrun=0.
- cpu_req=1 during cycles 10-14 of a copy -> src_rd=0 and src_addr frozen at 9 for 5 cycles, dst_we=0 in cycles 11-15, frame_done delayed to cycle 167, all 160 words still correct.
- Second vsync at cycle 50 of a copy -> copy unaffected, overrun=1 from cycle 51 until reset. vsync in the frame_done cycle -> a new copy starts the next cycle.
- Reset asserted at cycle 80 -> outputs return to reset values immediately, no frame_done, next vsync restarts from address 0.
- vsync with enable=0 -> without the macro: busy stays 0 and there are no writes. With LCD_SNAPSHOT_BLANK_EN: 160 writes of 0, src_rd=0 throughout, frame_done in cycle 162 even with cpu_req=1 throughout.
- enable dropped at cycle 20 of a copy -> the copy completes with all 160 writes.
